// File: rtl/util_axis_rr_arbiter.sv
// util_axis_rr_arbiter: round-robin N:1 AXI-Stream arbiter with a registered output beat.
// Grants may be held per packet (tlast) or per beat.
module util_axis_rr_arbiter #(
    parameter int BUS_WIDTH   = 1,
    parameter int NUM_PORTS   = 4,
    parameter int PACKET_MODE = 1
) (
    input  logic                             aclk,
    input  logic                             arstn,
    input  logic [NUM_PORTS*BUS_WIDTH*8-1:0] s_axis_tdata,
    input  logic [NUM_PORTS-1:0]             s_axis_tvalid,
    input  logic [NUM_PORTS-1:0]             s_axis_tlast,
    output logic [NUM_PORTS-1:0]             s_axis_tready,
    output logic [BUS_WIDTH*8-1:0]           m_axis_tdata,
    output logic                             m_axis_tvalid,
    output logic                             m_axis_tlast,
    output logic [$clog2(NUM_PORTS)-1:0]     m_axis_tdest,
    input  logic                             m_axis_tready
);
    localparam int DW = BUS_WIDTH * 8;
    localparam int IW = $clog2(NUM_PORTS);
    typedef enum logic {ARB, GRANT} state_t;
    state_t state, state_nxt;
    logic [IW-1:0] grant, last_grant, pick, idx;
    logic hit, accept, beat_last;
    logic [DW-1:0] beat_data;
    // First requester strictly after the previous grant, wrapping to port 0.
    always_comb begin
        hit = 1'b0;
        pick = '0;
        idx = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            idx = IW'((int'(last_grant) + k) % NUM_PORTS);
            if (!hit && s_axis_tvalid[idx]) begin
                hit = 1'b1;
                pick = idx;
            end
        end
    end
    always_comb begin
        s_axis_tready = '0;
        if (state == GRANT && arstn) s_axis_tready[grant] = !m_axis_tvalid || m_axis_tready;
    end
    assign accept = s_axis_tvalid[grant] && s_axis_tready[grant];
    assign beat_last = s_axis_tlast[grant];
    assign beat_data = s_axis_tdata[int'(grant)*DW +: DW];
    always_comb begin
        state_nxt = state;
        state_nxt = (state == ARB) ? (hit ? GRANT : ARB)
                  : (accept && (PACKET_MODE == 0 || beat_last)) ? ARB : GRANT;
    end
    always_ff @(posedge aclk) begin
        if (!arstn) begin
            state <= ARB;
            grant <= '0;
            last_grant <= IW'(NUM_PORTS - 1);
            m_axis_tdata <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast <= 1'b0;
            m_axis_tdest <= '0;
        end else begin
            state <= state_nxt;
            if (state == ARB && hit) grant <= pick;
            if (state == GRANT && state_nxt == ARB) last_grant <= grant;
            if (accept) begin
                m_axis_tdata <= beat_data;
                m_axis_tlast <= beat_last;
                m_axis_tdest <= grant;
                m_axis_tvalid <= 1'b1;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_util_axis_rr_arbiter.sv
// tb_util_axis_rr_arbiter: directed and randomized checks of the round-robin arbiter
// against per-port source/scoreboard queues; a second instance covers per-beat mode.
module tb_util_axis_rr_arbiter;
    localparam int NP = 4;
    logic aclk = 1'b0;
    logic arstn = 1'b0;
    logic [NP*8-1:0] s_tdata;
    logic [NP-1:0] s_tvalid, s_tlast, rdy0, rdy1, rdy;
    logic [7:0] md0, md1, md;
    logic mv0, mv1, mv, ml0, ml1, ml;
    logic [1:0] mt0, mt1, mt;
    logic m_tready;
    logic sel;

    always #5 aclk = ~aclk;

    util_axis_rr_arbiter #(.BUS_WIDTH(1), .NUM_PORTS(NP), .PACKET_MODE(1)) u0 (
        .aclk(aclk), .arstn(arstn), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
        .s_axis_tlast(s_tlast), .s_axis_tready(rdy0), .m_axis_tdata(md0), .m_axis_tvalid(mv0),
        .m_axis_tlast(ml0), .m_axis_tdest(mt0), .m_axis_tready(m_tready));
    util_axis_rr_arbiter #(.BUS_WIDTH(1), .NUM_PORTS(NP), .PACKET_MODE(0)) u1 (
        .aclk(aclk), .arstn(arstn), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
        .s_axis_tlast(s_tlast), .s_axis_tready(rdy1), .m_axis_tdata(md1), .m_axis_tvalid(mv1),
        .m_axis_tlast(ml1), .m_axis_tdest(mt1), .m_axis_tready(m_tready));

    assign rdy = sel ? rdy1 : rdy0;
    assign md = sel ? md1 : md0;
    assign mv = sel ? mv1 : mv0;
    assign ml = sel ? ml1 : ml0;
    assign mt = sel ? mt1 : mt0;

    // Beats still to be offered per port, and beats accepted but not yet seen downstream.
    logic [8:0] src_q[NP][$];
    logic [8:0] exp_q[NP][$];
    int out_dest[$];
    int out_cyc[$];
    int acc[NP];
    logic [NP-1:0] hold;
    bit rdy_rand, gap, in_pkt, stall;
    int cur, cyc, errors, checks;
    logic [7:0] pd;
    logic pl;
    logic [1:0] pt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic load(input int p, input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) src_q[p].push_back({i == n - 1, base + 8'(i)});
    endtask

    function automatic bit idle();
        idle = !mv;
        for (int p = 0; p < NP; p++) if (src_q[p].size() > 0 || exp_q[p].size() > 0) idle = 0;
    endfunction

    task automatic tick();
        int d;
        logic [8:0] b;
        @(negedge aclk);
        if (stall) begin
            check("hold_valid", mv, 1);
            check("hold_data", md, pd);
            check("hold_last", ml, pl);
            check("hold_dest", mt, pt);
        end
        m_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        for (int p = 0; p < NP; p++) begin
            s_tvalid[p] = src_q[p].size() > 0 && !hold[p] && !(gap && $urandom_range(0, 3) == 0);
            s_tdata[p*8 +: 8] = src_q[p].size() > 0 ? src_q[p][0][7:0] : 8'h0;
            s_tlast[p] = src_q[p].size() > 0 && src_q[p][0][8];
        end
        #1;
        if (mv && m_tready) begin
            d = int'(mt);
            check("beat_expected", exp_q[d].size() > 0, 1);
            if (exp_q[d].size() > 0) begin
                b = exp_q[d].pop_front();
                check("beat_data", md, b[7:0]);
                check("beat_last", ml, b[8]);
            end
            if (!sel && in_pkt) check("pkt_atomic", d, cur);
            in_pkt = !ml;
            cur = d;
            out_dest.push_back(d);
            out_cyc.push_back(cyc);
        end
        for (int p = 0; p < NP; p++) begin
            if (s_tvalid[p] && rdy[p]) begin
                exp_q[p].push_back(src_q[p].pop_front());
                acc[p]++;
            end
        end
        stall = mv && !m_tready;
        pd = md;
        pl = ml;
        pt = mt;
        cyc++;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (n < budget && !idle()) begin
            tick();
            n++;
        end
        check("drain_done", idle(), 1);
    endtask

    task automatic do_reset();
        @(negedge aclk);
        arstn = 1'b0;
        s_tvalid = '0;
        m_tready = 1'b1;
        #1;
        check("rst_rdy_during", rdy, 0);
        @(posedge aclk);
        #1;
        arstn = 1'b1;
        for (int p = 0; p < NP; p++) begin
            src_q[p].delete();
            exp_q[p].delete();
            acc[p] = 0;
        end
        hold = '0;
        in_pkt = 0;
        stall = 0;
        cyc = 0;
        out_dest.delete();
        out_cyc.delete();
        @(negedge aclk);
        check("rst_valid", mv, 0);
        check("rst_last", ml, 0);
        check("rst_data", md, 0);
        check("rst_dest", mt, 0);
        check("rst_rdy_after", rdy, 0);
    endtask

    initial begin
        int cnt0, cnt2, n, len;
        s_tdata = '0;
        s_tvalid = '0;
        s_tlast = '0;
        m_tready = 1'b1;
        sel = 1'b0;
        hold = '0;
        rdy_rand = 0;
        gap = 0;
        errors = 0;
        checks = 0;

        // All four ports with 3-beat packets: tdest 0..3, one bubble between packets.
        do_reset();
        for (int p = 0; p < NP; p++) load(p, 3, 8'(8'h40 + p * 16));
        drain(200);
        check("rr_count", out_dest.size(), 12);
        for (int i = 0; i < out_dest.size(); i++) begin
            check("rr_dest", out_dest[i], i / 3);
            if (i > 0) check("rr_gap", out_cyc[i] - out_cyc[i-1], (i % 3 == 0) ? 2 : 1);
        end

        // Port 1 arrives mid-packet of port 2 and must wait for its tlast.
        do_reset();
        load(2, 3, 8'h10);
        for (int i = 0; i < 20 && acc[2] < 1; i++) tick();
        check("p2_started", acc[2], 1);
        load(1, 2, 8'h20);
        drain(100);
        check("pkt_count", out_dest.size(), 5);
        for (int i = 0; i < out_dest.size(); i++) check("pkt_dest", out_dest[i], i < 3 ? 2 : 1);

        // Granted port 0 stalls for 5 cycles; port 1 must stay locked out.
        do_reset();
        load(0, 4, 8'hA0);
        load(1, 2, 8'hB0);
        for (int i = 0; i < 20 && acc[0] < 2; i++) tick();
        hold[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_rdy", rdy, 4'b0001);
        end
        hold[0] = 1'b0;
        drain(100);
        check("stall_count", out_dest.size(), 6);
        for (int i = 0; i < out_dest.size(); i++) check("stall_dest", out_dest[i], i < 4 ? 0 : 1);

        // Reset mid-packet from port 3: held beat dropped, lowest valid port wins next.
        do_reset();
        load(3, 4, 8'h30);
        for (int i = 0; i < 20 && acc[3] < 2; i++) tick();
        tick();
        check("pre_rst_valid", mv, 1);
        do_reset();
        load(3, 2, 8'h50);
        load(1, 2, 8'h60);
        drain(100);
        check("post_rst_count", out_dest.size(), 4);
        if (out_dest.size() > 0) check("post_rst_first", out_dest[0], 1);

        // Random backpressure and valid gaps, 100 bytes from ports 0 and 2.
        do_reset();
        rdy_rand = 1;
        gap = 1;
        foreach (src_q[p]) begin
            if (p == 0 || p == 2) begin
                n = 0;
                while (n < 50) begin
                    len = $urandom_range(1, 4);
                    if (n + len > 50) len = 50 - n;
                    load(p, len, 8'($urandom));
                    n += len;
                end
            end
        end
        drain(3000);
        cnt0 = 0;
        cnt2 = 0;
        foreach (out_dest[i]) begin
            if (out_dest[i] == 0) cnt0++;
            if (out_dest[i] == 2) cnt2++;
        end
        check("rand_cnt0", cnt0, 50);
        check("rand_cnt2", cnt2, 50);
        check("rand_total", out_dest.size(), 100);
        rdy_rand = 0;
        gap = 0;

        // Per-beat mode: ports 0 and 1 alternate with a bubble per beat.
        sel = 1'b1;
        do_reset();
        load(0, 4, 8'h70);
        load(1, 4, 8'h80);
        drain(200);
        check("beat_count", out_dest.size(), 8);
        for (int i = 0; i < out_dest.size(); i++) begin
            check("beat_dest", out_dest[i], i % 2);
            if (i > 0) check("beat_gap", out_cyc[i] - out_cyc[i-1], 2);
        end
        sel = 1'b0;
        do_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
